// File: rtl/calc_latmon_pkg.sv
// calc_latmon_pkg: shared FSM state type and default widths for calc_latency_monitor (rev 1.0)
// Optional feature macro used by this block: CALC_LATMON_STARVE_EN
`default_nettype none

package calc_latmon_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int DEF_NUM_PORTS    = 4;
  localparam int DEF_CMD_W        = 4;
  localparam int DEF_RESP_W       = 2;
  localparam int DEF_LAT_W        = 16;
  localparam int DEF_CNT_W        = 32;
  localparam int DEF_STARVE_LIMIT = 64;

endpackage

`default_nettype wire

// File: rtl/calc_latmon_port.sv
// calc_latmon_port: one monitored port -- FSM, saturating latency timer, statistics, sticky flags (rev 1.0)
// Starvation detection is compiled in only with CALC_LATMON_STARVE_EN defined.
`default_nettype none

module calc_latmon_port
  import calc_latmon_pkg::*;
#(
  parameter int CMD_W  = DEF_CMD_W,
  parameter int RESP_W = DEF_RESP_W,
  parameter int LAT_W  = DEF_LAT_W,
  parameter int CNT_W  = DEF_CNT_W
`ifdef CALC_LATMON_STARVE_EN
  ,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  total_o,
  output logic [LAT_W-1:0]  min_o,
  output logic [LAT_W-1:0]  max_o,
  output logic              done_o,
  output logic              starve_o,
  output logic              proto_err_o
);

  state_e           state_q;
  logic [LAT_W-1:0] lat_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] total_q;
  logic [LAT_W-1:0] min_q;
  logic [LAT_W-1:0] max_q;
  logic             done_q;
  logic             starve_q;
  logic             err_q;

  logic             cmd_v;
  logic             resp_v;
  logic             complete;
  logic             err_set;
  logic             starve_hit;
  logic [LAT_W-1:0] lat_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   total_sum;
  logic [CNT_W-1:0] total_d;
  logic [LAT_W-1:0] min_d;
  logic [LAT_W-1:0] max_d;

  always_comb begin
    cmd_v     = |cmd_i;
    resp_v    = |resp_i;
    complete  = (state_q == WAIT) && resp_v;
    // A response with no open request, or a command on top of one, is a protocol error.
    err_set   = (state_q == WAIT) ? cmd_v : resp_v;
    lat_d     = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);
    count_d   = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    total_sum = {1'b0, total_q} + (CNT_W+1)'(lat_q);
    total_d   = total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
    min_d     = (lat_q < min_q) ? lat_q : min_q;
    max_d     = (lat_q > max_q) ? lat_q : max_q;
  end

`ifdef CALC_LATMON_STARVE_EN
  assign starve_hit = (state_q == WAIT) && (lat_q == LAT_W'(STARVE_LIMIT));
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      count_q  <= '0;
      total_q  <= '0;
      min_q    <= '1;
      max_q    <= '0;
      done_q   <= 1'b0;
      starve_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= complete;
      case (state_q)
        IDLE: begin
          if (enable_i && cmd_v) begin
            state_q <= WAIT;
            lat_q   <= LAT_W'(1);
          end
        end
        WAIT: begin
          if (resp_v) begin
            state_q <= IDLE;
          end else begin
            lat_q <= lat_d;
          end
        end
        default: state_q <= IDLE;
      endcase
      // clear takes priority over a same-cycle completion or flag event; FSM and timer keep running.
      if (clear_i) begin
        count_q  <= '0;
        total_q  <= '0;
        min_q    <= '1;
        max_q    <= '0;
        starve_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        if (complete) begin
          count_q <= count_d;
          total_q <= total_d;
          min_q   <= min_d;
          max_q   <= max_d;
        end
        if (err_set) begin
          err_q <= 1'b1;
        end
        if (starve_hit) begin
          starve_q <= 1'b1;
        end
      end
    end
  end

  assign count_o     = count_q;
  assign total_o     = total_q;
  assign min_o       = min_q;
  assign max_o       = max_q;
  assign done_o      = done_q;
  assign starve_o    = starve_q;
  assign proto_err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/calc_latency_monitor.sv
// calc_latency_monitor: per-port request/response latency statistics with registered read-back (rev 1.0)
// Define CALC_LATMON_STARVE_EN to enable sticky starvation flags at STARVE_LIMIT cycles.
`default_nettype none

module calc_latency_monitor
  import calc_latmon_pkg::*;
#(
  parameter int NUM_PORTS    = DEF_NUM_PORTS,
  parameter int CMD_W        = DEF_CMD_W,
  parameter int RESP_W       = DEF_RESP_W,
  parameter int LAT_W        = DEF_LAT_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
  input  logic [NUM_PORTS*RESP_W-1:0] out_resp,
  input  logic [PORT_W-1:0]           rd_port,
  output logic [CNT_W-1:0]            rd_count,
  output logic [CNT_W-1:0]            rd_total,
  output logic [LAT_W-1:0]            rd_min,
  output logic [LAT_W-1:0]            rd_max,
  output logic [NUM_PORTS-1:0]        done_mask,
  output logic [NUM_PORTS-1:0]        starve,
  output logic [NUM_PORTS-1:0]        proto_err,
  output logic                        report_valid
);

  if (NUM_PORTS < 1 || NUM_PORTS > 16 || STARVE_LIMIT < 1 || CNT_W < LAT_W) begin : g_cfg_check
    $error("calc_latency_monitor: unsupported parameter combination");
  end

  logic [CNT_W-1:0] port_count [NUM_PORTS];
  logic [CNT_W-1:0] port_total [NUM_PORTS];
  logic [LAT_W-1:0] port_min   [NUM_PORTS];
  logic [LAT_W-1:0] port_max   [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc_latmon_port #(
      .CMD_W  (CMD_W),
      .RESP_W (RESP_W),
      .LAT_W  (LAT_W),
      .CNT_W  (CNT_W)
`ifdef CALC_LATMON_STARVE_EN
      ,
      .STARVE_LIMIT (STARVE_LIMIT)
`endif
    ) u_port (
      .clk_i       (c_clk),
      .rst_i       (reset),
      .enable_i    (enable),
      .clear_i     (clear),
      .cmd_i       (req_cmd_in[p*CMD_W +: CMD_W]),
      .resp_i      (out_resp[p*RESP_W +: RESP_W]),
      .count_o     (port_count[p]),
      .total_o     (port_total[p]),
      .min_o       (port_min[p]),
      .max_o       (port_max[p]),
      .done_o      (done_mask[p]),
      .starve_o    (starve[p]),
      .proto_err_o (proto_err[p])
    );
  end

  logic             enable_q;
  logic             report_valid_q;
  logic [CNT_W-1:0] rd_count_d, rd_count_q;
  logic [CNT_W-1:0] rd_total_d, rd_total_q;
  logic [LAT_W-1:0] rd_min_d,   rd_min_q;
  logic [LAT_W-1:0] rd_max_d,   rd_max_q;

  always_comb begin
    rd_count_d = '0;
    rd_total_d = '0;
    rd_min_d   = '0;
    rd_max_d   = '0;
    if (32'(rd_port) < NUM_PORTS) begin
      rd_count_d = port_count[rd_port];
      rd_total_d = port_total[rd_port];
      rd_min_d   = port_min[rd_port];
      rd_max_d   = port_max[rd_port];
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      enable_q       <= 1'b0;
      report_valid_q <= 1'b0;
      rd_count_q     <= '0;
      rd_total_q     <= '0;
      rd_min_q       <= '0;
      rd_max_q       <= '0;
    end else begin
      enable_q       <= enable;
      report_valid_q <= enable_q & ~enable;
      rd_count_q     <= rd_count_d;
      rd_total_q     <= rd_total_d;
      rd_min_q       <= rd_min_d;
      rd_max_q       <= rd_max_d;
    end
  end

  assign rd_count     = rd_count_q;
  assign rd_total     = rd_total_q;
  assign rd_min       = rd_min_q;
  assign rd_max       = rd_max_q;
  assign report_valid = report_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_latency_monitor.sv
// tb_calc_latency_monitor: directed scoreboard bench for calc_latency_monitor (STARVE_LIMIT=8).
`default_nettype none

module tb_calc_latency_monitor;

  localparam int NP = 4;
  localparam int CW = 4;
  localparam int RW = 2;
  localparam int LW = 16;
  localparam int KW = 32;

  logic              c_clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic [NP*CW-1:0]  req_cmd_in = '0;
  logic [NP*RW-1:0]  out_resp = '0;
  logic [1:0]        rd_port = '0;
  logic [KW-1:0]     rd_count;
  logic [KW-1:0]     rd_total;
  logic [LW-1:0]     rd_min;
  logic [LW-1:0]     rd_max;
  logic [NP-1:0]     done_mask;
  logic [NP-1:0]     starve;
  logic [NP-1:0]     proto_err;
  logic              report_valid;

  calc_latency_monitor #(
    .NUM_PORTS    (NP),
    .CMD_W        (CW),
    .RESP_W       (RW),
    .LAT_W        (LW),
    .CNT_W        (KW),
    .STARVE_LIMIT (8)
  ) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .req_cmd_in   (req_cmd_in),
    .out_resp     (out_resp),
    .rd_port      (rd_port),
    .rd_count     (rd_count),
    .rd_total     (rd_total),
    .rd_min       (rd_min),
    .rd_max       (rd_max),
    .done_mask    (done_mask),
    .starve       (starve),
    .proto_err    (proto_err),
    .report_valid (report_valid)
  );

  always #5 c_clk = ~c_clk;

  int n_checks = 0;
  int n_errors = 0;
  int edges = 0;

  always @(posedge c_clk) edges <= edges + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard of expected done_mask pulses, keyed by the clock edge after which they appear.
  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } done_exp_t;
  done_exp_t exp_q[$];

  task automatic expect_done(input logic [3:0] mask);
    done_exp_t e;
    e.cyc  = edges + 1;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  always @(negedge c_clk) begin : mon
    logic [3:0] want;
    want = 4'b0000;
    if (exp_q.size() > 0 && exp_q[0].cyc == edges) begin
      want = exp_q[0].mask;
      void'(exp_q.pop_front());
    end
    check_eq("done_mask", {60'd0, done_mask}, {60'd0, want});
  end

  logic [KW-1:0] m_cnt [NP];
  logic [KW-1:0] m_tot [NP];
  logic [LW-1:0] m_min [NP];
  logic [LW-1:0] m_max [NP];

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      m_cnt[i] = '0;
      m_tot[i] = '0;
      m_min[i] = '1;
      m_max[i] = '0;
    end
  endtask

  task automatic record(input int p, input int lat);
    m_cnt[p] = m_cnt[p] + 1;
    m_tot[p] = m_tot[p] + KW'(lat);
    if (LW'(lat) < m_min[p]) m_min[p] = LW'(lat);
    if (LW'(lat) > m_max[p]) m_max[p] = LW'(lat);
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_cmd(input int p, input logic [CW-1:0] v);
    req_cmd_in[p*CW +: CW] = v;
  endtask

  task automatic set_resp(input int p, input logic [RW-1:0] v);
    out_resp[p*RW +: RW] = v;
  endtask

  task automatic check_port(input int p);
    rd_port = 2'(p);
    tick();
    check_eq($sformatf("p%0d_count", p), {32'd0, rd_count}, {32'd0, m_cnt[p]});
    check_eq($sformatf("p%0d_total", p), {32'd0, rd_total}, {32'd0, m_tot[p]});
    check_eq($sformatf("p%0d_min", p),   {48'd0, rd_min},   {48'd0, m_min[p]});
    check_eq($sformatf("p%0d_max", p),   {48'd0, rd_max},   {48'd0, m_max[p]});
  endtask

  logic [3:0] starve_exp;

  initial begin
`ifdef CALC_LATMON_STARVE_EN
    starve_exp = 4'b0001;
`else
    starve_exp = 4'b0000;
`endif
    model_clear();
    tick();
    tick();
    check_eq("rst_count",  {32'd0, rd_count}, 64'd0);
    check_eq("rst_total",  {32'd0, rd_total}, 64'd0);
    check_eq("rst_min",    {48'd0, rd_min},   64'd0);
    check_eq("rst_max",    {48'd0, rd_max},   64'd0);
    check_eq("rst_starve", {60'd0, starve},   64'd0);
    check_eq("rst_err",    {60'd0, proto_err}, 64'd0);
    check_eq("rst_report", {63'd0, report_valid}, 64'd0);
    reset = 1'b0;
    tick();
    enable = 1'b1;
    check_port(0);

    // Port 1, latency 4.
    set_cmd(1, 4'h1);
    tick();
    set_cmd(1, 4'h0);
    repeat (3) tick();
    set_resp(1, 2'b01);
    expect_done(4'b0010);
    record(1, 4);
    tick();
    set_resp(1, 2'b00);
    check_port(1);

    // Ports 0 and 3 together, latency 3 each.
    set_cmd(0, 4'h2);
    set_cmd(3, 4'h8);
    tick();
    set_cmd(0, 4'h0);
    set_cmd(3, 4'h0);
    repeat (2) tick();
    set_resp(0, 2'b10);
    set_resp(3, 2'b11);
    expect_done(4'b1001);
    record(0, 3);
    record(3, 3);
    tick();
    set_resp(0, 2'b00);
    set_resp(3, 2'b00);
    check_port(0);
    check_port(3);

    // Port 2: second command while waiting flags an error and does not restart the timer.
    set_cmd(2, 4'h3);
    tick();
    set_cmd(2, 4'h0);
    repeat (2) tick();
    set_cmd(2, 4'h5);
    tick();
    set_cmd(2, 4'h0);
    check_eq("err_cmd_in_wait", {60'd0, proto_err}, 64'h4);
    repeat (2) tick();
    set_resp(2, 2'b01);
    expect_done(4'b0100);
    record(2, 6);
    tick();
    set_resp(2, 2'b00);
    check_port(2);

    // Port 0 held past STARVE_LIMIT.
    set_cmd(0, 4'h1);
    tick();
    set_cmd(0, 4'h0);
    repeat (7) tick();
    check_eq("starve_early", {60'd0, starve}, 64'd0);
    tick();
    check_eq("starve_at_limit", {60'd0, starve}, {60'd0, starve_exp});
    set_resp(0, 2'b01);
    expect_done(4'b0001);
    record(0, 9);
    tick();
    set_resp(0, 2'b00);
    check_port(0);
    check_eq("err_sticky", {60'd0, proto_err}, 64'h4);
    check_eq("starve_sticky", {60'd0, starve}, {60'd0, starve_exp});

    // clear coinciding with a port 1 completion: done pulses, nothing recorded.
    set_cmd(1, 4'h1);
    tick();
    set_cmd(1, 4'h0);
    tick();
    set_resp(1, 2'b01);
    clear = 1'b1;
    expect_done(4'b0010);
    model_clear();
    tick();
    clear = 1'b0;
    set_resp(1, 2'b00);
    check_eq("clr_err",    {60'd0, proto_err}, 64'd0);
    check_eq("clr_starve", {60'd0, starve},    64'd0);
    check_port(1);
    check_port(0);

    // Reset in the middle of a port 3 wait; the late response is a protocol error.
    set_cmd(3, 4'h1);
    tick();
    set_cmd(3, 4'h0);
    tick();
    reset = 1'b1;
    #1;
    check_eq("rst2_min",  {48'd0, rd_min},    64'd0);
    check_eq("rst2_err",  {60'd0, proto_err}, 64'd0);
    check_eq("rst2_done", {60'd0, done_mask}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    set_resp(3, 2'b01);
    tick();
    set_resp(3, 2'b00);
    check_eq("err_after_rst", {60'd0, proto_err}, 64'h8);
    check_port(3);

    // Response in the same cycle the command is accepted.
    set_cmd(0, 4'h1);
    set_resp(0, 2'b01);
    tick();
    set_cmd(0, 4'h0);
    set_resp(0, 2'b00);
    check_eq("err_resp_on_accept", {60'd0, proto_err}, 64'h9);
    tick();
    set_resp(0, 2'b10);
    expect_done(4'b0001);
    record(0, 2);
    tick();
    set_resp(0, 2'b00);
    check_port(0);

    // enable falls with port 1 in flight; a later port 2 command is ignored.
    set_cmd(1, 4'h1);
    tick();
    set_cmd(1, 4'h0);
    enable = 1'b0;
    check_eq("report_before", {63'd0, report_valid}, 64'd0);
    tick();
    check_eq("report_pulse", {63'd0, report_valid}, 64'd1);
    set_cmd(2, 4'h1);
    tick();
    check_eq("report_once_a", {63'd0, report_valid}, 64'd0);
    set_cmd(2, 4'h0);
    set_resp(1, 2'b01);
    expect_done(4'b0010);
    record(1, 3);
    tick();
    check_eq("report_once_b", {63'd0, report_valid}, 64'd0);
    set_resp(1, 2'b00);
    set_resp(2, 2'b01);
    tick();
    set_resp(2, 2'b00);
    check_eq("err_ignored_cmd", {60'd0, proto_err}, 64'hD);
    check_port(1);
    check_port(2);

    repeat (3) tick();
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
